// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
// Purely combinational; no flow control.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic         a_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  logic [W:0] r_sh;

  // When the subtraction happens the true result is below divisor, so W-bit modular math is exact.
  always_comb begin
    r_sh   = {r, a_msb};
    q_bit  = (r_sh >= {1'b0, divisor});
    r_next = q_bit ? (r_sh[W-1:0] - divisor) : r_sh[W-1:0];
  end

endmodule

// File: rtl/seq_div_unsigned.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, done width1 edges after the start edge.
// Starts only on a rising edge of en seen in IDLE; rises while busy are dropped, results hold until the next op.
module seq_div_unsigned
  import div_pkg::*;
#(
  parameter int width1 = 16,
  parameter int width2 = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [width1-1:0] A,
  input  logic [width2-1:0] B,
  output logic [width1-1:0] quot,
  output logic [width2-1:0] rem,
  output logic              busy,
  output logic              done,
  output logic              dz
);

  localparam int CW = cnt_w(width1);
  localparam logic [CW-1:0] CNT_LAST = CW'(width1 - 1);

  div_state_t        state, state_nxt;
  logic              en_d;
  logic              start;
  logic              dz_req;
  logic              cnt_last;
  logic [width1-1:0] a_reg;
  logic [width2-1:0] d_reg;
  logic [width2-1:0] r_reg;
  logic [CW-1:0]     cnt;
  logic [width2-1:0] r_next;
  logic              q_bit;

  assign start    = en & ~en_d;
  assign cnt_last = (cnt == CNT_LAST);

  div_step #(.W(width2)) u_step (
    .r       (r_reg),
    .a_msb   (a_reg[width1-1]),
    .divisor (d_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // A zero divisor spends one CALC cycle resolving, so its done lands one edge after start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (dz_req || cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      en_d   <= 1'b0;
      dz_req <= 1'b0;
      a_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      quot   <= '0;
      rem    <= '0;
      dz     <= 1'b0;
    end else begin
      en_d <= en;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= A;
            d_reg  <= B;
            r_reg  <= '0;
            cnt    <= '0;
            dz_req <= (B == '0);
          end
        end
        CALC: begin
          if (dz_req) begin
            quot   <= '1;
            rem    <= '0;
            dz     <= 1'b1;
            dz_req <= 1'b0;
          end else begin
            a_reg <= {a_reg[width1-2:0], q_bit};
            r_reg <= r_next;
            cnt   <= cnt + 1'b1;
            if (cnt_last) begin
              quot <= {a_reg[width1-2:0], q_bit};
              rem  <= r_next;
              dz   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unsigned.sv
// Scoreboard bench for seq_div_unsigned at width1=16, width2=8.
module tb_seq_div_unsigned;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        en;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        busy;
  logic        done;
  logic        dz;

  int   n_checks;
  int   n_errors;
  int   done_cnt;
  exp_t sb[$];

  seq_div_unsigned #(.width1(16), .width2(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .A         (A),
    .B         (B),
    .quot      (quot),
    .rem       (rem),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Results are compared whenever the DUT raises done.
  always @(negedge sys_clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quot", 32'(quot), 32'(e.q));
        check("rem", 32'(rem), 32'(e.r));
        check("dz", 32'(dz), 32'(e.z));
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk); #1;
      n++;
      if (done === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b);
    int   n;
    exp_t e;
    en = 1'b0;
    @(posedge sys_clk); #1;
    A  = a;
    B  = b;
    en = 1'b1;
    if (b == 8'd0) e = '{q: 16'hFFFF, r: 8'd0, z: 1'b1};
    else           e = '{q: a / b, r: 8'(a % b), z: 1'b0};
    sb.push_back(e);
    @(posedge sys_clk); #1;
    if (b != 8'd0) check("busy_start", 32'(busy), 32'd1);
    wait_done(n);
    check("latency", n, (b == 8'd0) ? 32'd1 : 32'd16);
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge sys_clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("hold_quot", 32'(quot), 32'(e.q));
    check("hold_dz", 32'(dz), 32'(e.z));
  endtask

  initial begin
    int n;
    int d0;
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    sys_rst_n = 1'b0;
    en        = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    run_div(16'd1000, 8'd7);
    run_div(16'd65535, 8'd255);
    run_div(16'd65535, 8'd1);
    run_div(16'd5, 8'd9);
    run_div(16'd0, 8'd3);
    run_div(16'd1234, 8'd0);
    run_div(16'd50000, 8'd123);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom_range(255, 1));
      run_div(ra, rb);
    end

    // en held high; a second rise during CALC and operand changes must be ignored.
    en = 1'b0;
    @(posedge sys_clk); #1;
    A  = 16'd100;
    B  = 8'd10;
    en = 1'b1;
    sb.push_back('{q: 16'd10, r: 8'd0, z: 1'b0});
    d0 = done_cnt;
    @(posedge sys_clk); #1;
    repeat (5) @(posedge sys_clk);
    #1;
    en = 1'b0;
    A  = 16'd7;
    B  = 8'd0;
    @(posedge sys_clk); #1;
    en = 1'b1;
    repeat (33) @(posedge sys_clk);
    #1;
    check("single_done", done_cnt - d0, 32'd1);
    check("busy_after_hold", 32'(busy), 32'd0);

    // Reset mid-CALC, with en still high so release counts as a start.
    en = 1'b0;
    @(posedge sys_clk); #1;
    A  = 16'd1000;
    B  = 8'd7;
    en = 1'b1;
    @(posedge sys_clk); #1;
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    A = 16'd65533;
    B = 8'd255;
    @(posedge sys_clk); #1;
    check("mid_rst_quot", 32'(quot), 32'd0);
    check("mid_rst_rem", 32'(rem), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dz", 32'(dz), 32'd0);
    d0 = done_cnt;
    sb.push_back('{q: 16'd256, r: 8'd253, z: 1'b0});
    sys_rst_n = 1'b1;
    wait_done(n);
    check("latency_rst", n, 32'd17);
    check("no_done_from_aborted", done_cnt - d0, 32'd0);
    en = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
